sys_arr_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO holding BW-word beats. It sits between the AXI-stream slave side and the systolic-array dispatcher as the input FIFO; an identical instance buffers results ahead of the AXI-stream master side. It implements the FIFO_if master/slave contract: a push/pop handshake, full/empty status, and combinational head data, so the dispatcher can pop and consume in the same cycle.

---
 rtl/sys_arr_fifo_if.sv | 28 ++
 rtl/sys_arr_fifo.sv | 81 ++++++++
 tb/tb_sys_arr_fifo.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sys_arr_fifo_if.sv
// FIFO handshake bundle: push/pop requests, beat data and occupancy status.
// Optional error outputs exist only when SYS_ARR_FIFO_ERR_FLAGS_EN is defined.
interface sys_arr_fifo_if #(
  parameter int BW    = 2,
  parameter int DEPTH = 8
);
  logic                       push;
  logic [BW-1:0][31:0]        dat_in;
  logic                       pop;
  logic [BW-1:0][31:0]        dat_out;
  logic                       is_full;
  logic                       is_empty;
  logic [$clog2(DEPTH):0]     count;
`ifdef SYS_ARR_FIFO_ERR_FLAGS_EN
  logic                       overflow;
  logic                       underflow;

  modport slave  (input push, dat_in, pop,
                  output dat_out, is_full, is_empty, count, overflow, underflow);
  modport master (output push, dat_in, pop,
                  input dat_out, is_full, is_empty, count, overflow, underflow);
`else
  modport slave  (input push, dat_in, pop,
                  output dat_out, is_full, is_empty, count);
  modport master (output push, dat_in, pop,
                  input dat_out, is_full, is_empty, count);
`endif
endinterface

// File: rtl/sys_arr_fifo.sv
// First-word-fall-through beat FIFO with wrap-bit pointers and combinational head.
// Define SYS_ARR_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sys_arr_fifo #(
  parameter int BW    = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  sys_arr_fifo_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [BW-1:0][31:0] mem [DEPTH];
  logic [AW:0]         wr_ptr_reg;
  logic [AW:0]         rd_ptr_reg;
  logic [AW:0]         count_reg;
  logic                full;
  logic                empty;
  logic                push_acc;
  logic                pop_acc;
  logic [BW-1:0][31:0] head;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // A full FIFO refuses pushes even when a pop retires an entry this cycle.
  assign push_acc = f.push & ~full;
  assign pop_acc  = f.pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + ONE;
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + ONE;
      case ({push_acc, pop_acc})
        2'b10:   count_reg <= count_reg + ONE;
        2'b01:   count_reg <= count_reg - ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem[wr_ptr_reg[AW-1:0]] <= f.dat_in;
  end

  assign head = mem[rd_ptr_reg[AW-1:0]];

  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_out
      assign f.dat_out[gi] = empty ? 32'd0 : head[gi];
    end
  endgenerate

  assign f.is_full  = full;
  assign f.is_empty = empty;
  assign f.count    = count_reg;

`ifdef SYS_ARR_FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (f.push && full) overflow_reg  <= 1'b1;
      if (f.pop && empty) underflow_reg <= 1'b1;
    end
  end

  assign f.overflow  = overflow_reg;
  assign f.underflow = underflow_reg;
`endif
endmodule

// File: tb/tb_sys_arr_fifo.sv
// Randomized and directed bench for sys_arr_fifo against a queue reference model.
module tb_sys_arr_fifo;
  localparam int BW    = 2;
  localparam int DEPTH = 8;
  typedef logic [BW-1:0][31:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_arr_fifo_if #(.BW(BW), .DEPTH(DEPTH)) fi ();
  sys_arr_fifo #(.BW(BW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .f(fi.slave));

  beat_t mq[$];
  bit    exp_ovf = 1'b0;
  bit    exp_unf = 1'b0;
  bit    armed   = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string name, input logic [BW*32-1:0] act, input logic [BW*32-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compares every status output and the presented head against the model.
  always @(negedge clk) begin
    if (armed) begin
      beat_t head_exp;
      head_exp = (mq.size() != 0) ? mq[0] : '0;
      chk("count", {{(BW*32-4){1'b0}}, fi.count}, (BW*32)'(mq.size()));
      chk("is_empty", {{(BW*32-1){1'b0}}, fi.is_empty}, (BW*32)'(mq.size() == 0));
      chk("is_full", {{(BW*32-1){1'b0}}, fi.is_full}, (BW*32)'(mq.size() == DEPTH));
      chk("dat_out", fi.dat_out, head_exp);
`ifdef SYS_ARR_FIFO_ERR_FLAGS_EN
      chk("overflow", {{(BW*32-1){1'b0}}, fi.overflow}, (BW*32)'(exp_ovf));
      chk("underflow", {{(BW*32-1){1'b0}}, fi.underflow}, (BW*32)'(exp_unf));
`endif
    end
  end

  task automatic step(input bit p, input beat_t d, input bit q, input bit r);
    bit was_full;
    bit was_empty;
    fi.push   = p;
    fi.dat_in = d;
    fi.pop    = q;
    rst       = r;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    @(posedge clk);
    if (r) begin
      mq.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (p && was_full)  exp_ovf = 1'b1;
      if (q && was_empty) exp_unf = 1'b1;
      if (q && !was_empty) void'(mq.pop_front());
      if (p && !was_full)  mq.push_back(d);
    end
    $display("step rst=%0b push=%0b pop=%0b din=%h model_count=%0d", r, p, q, d, mq.size());
    #1;
  endtask

  function automatic beat_t mk(input int a, input int b);
    beat_t v;
    v[0] = 32'(a);
    v[1] = 32'(b);
    return v;
  endfunction

  task automatic drain();
    while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    fi.push = 1'b0;
    fi.pop = 1'b0;
    fi.dat_in = '0;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    armed = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);

    // Single beat in and out
    step(1'b1, mk(1, 2), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Fill, overfill, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(i, i), 1'b0, 1'b0);
    step(1'b1, mk(32'hFF, 32'hFF), 1'b0, 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b0);

    // Full with push and pop together, then push
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(16 + i, 100 + i), 1'b0, 1'b0);
    step(1'b1, mk(32'hAA, 32'hAB), 1'b1, 1'b0);
    step(1'b1, mk(32'hBA, 32'hBB), 1'b0, 1'b0);
    drain();

    // Steady state at three entries across pointer wraps
    for (int i = 0; i < 3; i++) step(1'b1, mk(200 + i, ~(200 + i)), 1'b0, 1'b0);
    for (int i = 3; i < 43; i++) step(1'b1, mk(200 + i, ~(200 + i)), 1'b1, 1'b0);
    drain();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, mk(300 + i, 400 + i), 1'b0, 1'b0);
    step(1'b1, mk(32'h55, 32'h66), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Error conditions: pop empty, then nine pushes
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, mk(500 + i, 600 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), mk($urandom, $urandom),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 2));
    end
    step(1'b0, '0, 1'b0, 1'b0);

    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
